// File: rtl/contador_pkg.sv
// Shared definitions for the multi-channel play counter.
// Mode constants and the per-channel next-count rule.
package contador_pkg;

  localparam int CW = 32;

  localparam logic MODO_WRAP = 1'b0;
  localparam logic MODO_SAT  = 1'b1;

  function automatic logic [CW-1:0] prox_contagem(
    input logic [CW-1:0] q,
    input logic [CW-1:0] lim,
    input logic          dec,
    input logic          modo
  );
    logic [CW-1:0] r;
    r = q;
    unique case (1'b1)
      (!dec && (q < lim)):
        r = q + 1'b1;
      (!dec && (q >= lim)):
        r = (modo == MODO_SAT) ? lim : '0;
      (dec && (q > lim)):
        r = lim;
      (dec && (q <= lim) && (q == '0)):
        r = (modo == MODO_SAT) ? '0 : lim;
      default:
        r = q - 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/contador_canal.sv
// One channel of the play counter.
// Holds its count and computes the next value.
module contador_canal
  import contador_pkg::*;
#(
  parameter int N = 6
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         dec,
  input  logic         modo,
  input  logic [N-1:0] lim,
  output logic [N-1:0] q,
  output logic [N-1:0] prox
);

  assign prox = N'(prox_contagem(CW'(q), CW'(lim), dec, modo));

  // Count register: clear wins over an enabled step.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= prox;
    end
  end

endmodule

// File: rtl/contador_jogadas_mc.sv
// Multi-channel play/round counter with shared limit.
// Limit register, channel select, flags and reach pulse.
module contador_jogadas_mc
  import contador_pkg::*;
#(
  parameter  int N  = 6,
  parameter  int M  = 32,
  parameter  int P  = 2,
  localparam int PW = (P > 1) ? $clog2(P) : 1
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           clr,
  input  logic [PW-1:0]  canal,
  input  logic           conta,
  input  logic           dec,
  input  logic           modo,
  input  logic           carrega,
  input  logic [N-1:0]   limite,
  output logic [N-1:0]   Q,
  output logic [P*N-1:0] Q_all,
  output logic [N-1:0]   lim,
  output logic [P-1:0]   fim,
  output logic           todos_fim,
  output logic           fim_pulse
);

  if ((N < 1) || (N > CW) || (P < 1) || (M < 1) ||
      (longint'(M) > ((longint'(1) << N) - 1))) begin : g_param_err
    $error("contador_jogadas_mc: bad N/M/P");
  end

  logic [N-1:0] lim_r;
  logic [N-1:0] q_r  [P];
  logic [N-1:0] prox [P];
  logic [P-1:0] en;
  logic         sel_ok;
  logic         op;
  logic [N-1:0] q_sel;
  logic [N-1:0] prox_sel;
  logic         pulse_d;

  assign sel_ok = (32'(canal) < P);
  assign op     = conta && !clr && sel_ok;

  for (genvar i = 0; i < P; i++) begin : g_canal
    assign en[i] = op && (canal == PW'(i));

    contador_canal #(
      .N(N)
    ) u_canal (
      .clock(clock),
      .rst  (rst),
      .clr  (clr),
      .en   (en[i]),
      .dec  (dec),
      .modo (modo),
      .lim  (lim_r),
      .q    (q_r[i]),
      .prox (prox[i])
    );

    assign Q_all[i*N +: N] = q_r[i];
    assign fim[i]          = (q_r[i] == lim_r);
  end

  // Selected channel's count and candidate next value.
  always_comb begin
    q_sel    = '0;
    prox_sel = '0;
    for (int i = 0; i < P; i++) begin
      if (sel_ok && (canal == PW'(i))) begin
        q_sel    = q_r[i];
        prox_sel = prox[i];
      end
    end
  end

  assign Q         = q_sel;
  assign lim       = lim_r;
  assign todos_fim = &fim;

  // Reach event uses the limit in force before any load.
  assign pulse_d = op && (q_sel != lim_r) && (prox_sel == lim_r);

  // Limit register; a zero limit is never accepted.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      lim_r <= N'(M);
    end else if (carrega && (limite != '0)) begin
      lim_r <= limite;
    end
  end

  // One-cycle reach pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      fim_pulse <= 1'b0;
    end else begin
      fim_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_contador_jogadas_mc.sv
// Bench for contador_jogadas_mc (N=4, M=5, P=2, plus P=3).
// Directed scenarios followed by random traffic vs. a model.
module tb_contador_jogadas_mc;

  localparam int N = 4;
  localparam int M = 5;
  localparam int P = 2;

  logic         clock = 1'b0;
  logic         rst;
  logic         clr;
  logic [0:0]   canal;
  logic [1:0]   canal3;
  logic         conta;
  logic         dec;
  logic         modo;
  logic         carrega;
  logic [N-1:0] limite;

  logic [N-1:0]   Q;
  logic [P*N-1:0] Q_all;
  logic [N-1:0]   lim;
  logic [P-1:0]   fim;
  logic           todos_fim;
  logic           fim_pulse;

  logic [N-1:0]   Q3;
  logic [3*N-1:0] Q_all3;
  logic [N-1:0]   lim3;
  logic [2:0]     fim3;
  logic           todos_fim3;
  logic           fim_pulse3;

  contador_jogadas_mc #(.N(N), .M(M), .P(P)) u_dut (
    .clock(clock), .rst(rst), .clr(clr), .canal(canal),
    .conta(conta), .dec(dec), .modo(modo),
    .carrega(carrega), .limite(limite),
    .Q(Q), .Q_all(Q_all), .lim(lim), .fim(fim),
    .todos_fim(todos_fim), .fim_pulse(fim_pulse)
  );

  contador_jogadas_mc #(.N(N), .M(M), .P(3)) u_dut3 (
    .clock(clock), .rst(rst), .clr(clr), .canal(canal3),
    .conta(conta), .dec(dec), .modo(modo),
    .carrega(carrega), .limite(limite),
    .Q(Q3), .Q_all(Q_all3), .lim(lim3), .fim(fim3),
    .todos_fim(todos_fim3), .fim_pulse(fim_pulse3)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  int mc[P];
  int ml;
  int mp;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_next(int q, int l, bit d, bit m);
    if (!d) return (q < l) ? q + 1 : (m ? l : 0);
    if (q > l) return l;
    if (q == 0) return m ? 0 : l;
    return q - 1;
  endfunction

  task automatic check_all();
    chk("q", int'(Q), mc[canal]);
    chk("q_all", int'(Q_all), mc[1] * 16 + mc[0]);
    chk("lim", int'(lim), ml);
    chk("fim0", int'(fim[0]), int'(mc[0] == ml));
    chk("fim1", int'(fim[1]), int'(mc[1] == ml));
    chk("todos_fim", int'(todos_fim),
        int'((mc[0] == ml) && (mc[1] == ml)));
    chk("fim_pulse", int'(fim_pulse), mp);
    chk("p3_q", int'(Q3), 0);
    chk("p3_q_all", int'(Q_all3), 0);
    chk("p3_lim", int'(lim3), ml);
  endtask

  task automatic tick();
    int n[P];
    int l;
    int p;
    n = mc;
    l = ml;
    p = 0;
    if (clr) begin
      for (int i = 0; i < P; i++) n[i] = 0;
    end else if (conta) begin
      n[canal] = ref_next(mc[canal], ml, dec, modo);
      p = int'((mc[canal] != ml) && (n[canal] == ml));
    end
    if (carrega && (limite != 0)) l = int'(limite);
    @(posedge clock);
    #1;
    mc = n;
    ml = l;
    mp = p;
    check_all();
  endtask

  task automatic idle();
    clr = 0; conta = 0; carrega = 0; limite = '0;
  endtask

  int exp_a[7] = '{1, 2, 3, 4, 5, 0, 1};
  int exp_p[7] = '{0, 0, 0, 0, 1, 0, 0};
  int exp_d[6] = '{4, 3, 2, 1, 0, 0};

  initial begin
    rst = 1; canal = 0; canal3 = 2'd3;
    dec = 0; modo = 0;
    idle();
    for (int i = 0; i < P; i++) mc[i] = 0;
    ml = M;
    mp = 0;
    #12;
    check_all();
    @(negedge clock);
    rst = 0;

    conta = 1; dec = 0; modo = 0; canal = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("s1_q", int'(Q), exp_a[k]);
      chk("s1_pulse", int'(fim_pulse), exp_p[k]);
      chk("s1_ch1", int'(Q_all[7:4]), 0);
    end

    idle(); clr = 1; tick();
    clr = 0; conta = 1; modo = 1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("s2_q", int'(Q), (k < 5) ? k + 1 : 5);
    end
    dec = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("s2_dn", int'(Q), exp_d[k]);
    end

    modo = 0; dec = 1; tick();
    chk("s3_wrap", int'(Q), 5);
    chk("s3_pulse", int'(fim_pulse), 1);
    idle(); carrega = 1; limite = 4'd3; tick();
    chk("s3_lim", int'(lim), 3);
    chk("s3_nopulse", int'(fim_pulse), 0);
    idle(); conta = 1; dec = 0; tick();
    chk("s3_up", int'(Q), 0);

    idle(); carrega = 1; limite = 4'd5; clr = 1; tick();
    chk("s4_lim", int'(lim), 5);
    idle(); conta = 1; dec = 0; canal = 0;
    repeat (5) tick();
    chk("s4_tf0", int'(todos_fim), 0);
    canal = 1;
    repeat (4) tick();
    chk("s4_tf1", int'(todos_fim), 0);
    tick();
    chk("s4_tf2", int'(todos_fim), 1);

    idle(); clr = 1; tick();
    idle(); conta = 1; canal = 0;
    repeat (4) tick();
    clr = 1; tick();
    chk("s5_q", int'(Q), 0);
    chk("s5_pulse", int'(fim_pulse), 0);

    idle(); conta = 1;
    repeat (5) tick();
    chk("s6_pre", int'(fim_pulse), 1);
    #2 rst = 1;
    #1;
    for (int i = 0; i < P; i++) mc[i] = 0;
    ml = M;
    mp = 0;
    chk("s6_q", int'(Q), 0);
    chk("s6_pulse", int'(fim_pulse), 0);
    check_all();
    @(negedge clock);
    rst = 0;
    idle();

    carrega = 1; limite = '0; tick();
    chk("s7_lim", int'(lim), 5);

    for (int k = 0; k < 400; k++) begin
      conta   = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 19) == 0);
      carrega = ($urandom_range(0, 9) == 0);
      limite  = N'($urandom_range(0, 15));
      dec     = 1'($urandom_range(0, 1));
      modo    = 1'($urandom_range(0, 1));
      canal   = 1'($urandom_range(0, 1));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_jogadas_mc.md
Name: contador_jogadas_mc

Overview:
Multi-channel play/round counter for the game datapath. Holds one count per player, with a runtime-programmable limit shared by all channels. Supports up/down counting and wrap or saturate behaviour at the ends of the range. Produces per-channel limit flags, an all-done flag, and a registered one-cycle pulse when the selected channel reaches the limit. Sits between the game FSM and the score/round logic.

Parameters:
N, 6, count and limit width in bits.
M, 32, reset value of the limit register; elaboration error if M > 2^N-1 or M == 0.
P, 2, number of channels (players), P >= 1.
PW (localparam), max(1, clog2(P)), width of the channel select.

Ports:
clock  in  1  rising-edge clock.
rst  in  1  reset.
clr  in  1  synchronous clear of all channel counts.
canal  in  PW  selects the channel that counting and Q refer to.
conta  in  1  count enable for the selected channel.
dec  in  1  direction: 0 counts up, 1 counts down.
modo  in  1  end-of-range mode: 0 wrap, 1 saturate.
carrega  in  1  loads limite into the limit register.
limite  in  N  new limit value.
Q  out  N  count of the selected channel; 0 if canal >= P.
Q_all  out  P*N  all counts; channel i is at bits [i*N +: N].
lim  out  N  current limit register.
fim  out  P  fim[i] = (count[i] == lim).
todos_fim  out  1  AND of all fim bits.
fim_pulse  out  1  registered one-cycle "selected channel reached limit" event.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clock. While rst is high, all counts = 0, lim = M, fim_pulse = 0.
- Derived outputs: fim, todos_fim, Q and lim are combinational decodes of registered state only.
- clr: all counts go to 0 on the next edge; any count operation in that cycle is dropped. lim is unaffected. fim_pulse = 0 on that edge.
- carrega:
  - lim <= limite on the next edge.
  - limite == 0 is ignored and lim is held.
  - A count operation in the same cycle compares against the old lim.
  - carrega and clr in the same cycle are both honoured.
- Count operation: conta = 1, clr = 0 and canal < P. Only the selected channel changes; an invalid canal is a no-op.
- Up (dec = 0):
  - Q < lim: Q + 1.
  - Q == lim: modo 0 gives 0; modo 1 holds lim.
  - Q > lim (limit was lowered): modo 0 gives 0; modo 1 gives lim.
- Down (dec = 1):
  - 0 < Q <= lim: Q - 1.
  - Q == 0: modo 0 gives lim; modo 1 holds 0.
  - Q > lim: lim in both modes.
- fim_pulse:
  - Set to 1 on the edge where a count operation moves the selected channel from a value != lim to lim.
  - Otherwise 0 on every edge. It is never held for two cycles by an unchanged count.
  - A load that makes an existing count equal the new lim does not pulse.
  - Saturating at lim does not re-pulse.
- Latency: one clock from inputs to the count, lim and fim_pulse registers.
- Arithmetic: all in N bits; no carry-out is ever exposed.

Decomposition:
- Package contador_pkg:
  - mode constants MODO_WRAP = 0 and MODO_SAT = 1;
  - a function computing the next count from (q, lim, dec, modo), pure combinational.
- Sub-module contador_canal: one channel register with enable, clr and next-value logic, instantiated P times via generate.
- The top level holds the limit register, channel decode, output mux and fim_pulse register.

Test Plan:
Bench configuration for all scenarios: N = 4, M = 5, P = 2.
- Reset then conta = 1, dec = 0, modo = 0, canal = 0 for 7 cycles -> Q reads 1, 2, 3, 4, 5, 0, 1; fim[0] high only while Q = 5; fim_pulse high exactly one cycle, on the edge that produced 5; Q_all[7:4] stays 0.
- Same stimulus with modo = 1 -> Q sticks at 5, fim[0] stays high, one single fim_pulse. Then dec = 1 -> Q goes 4, 3, 2, 1, 0, 0.
- modo = 0, dec = 1 from Q = 0 -> Q = 5 and fim_pulse fires. Then carrega with limite = 3 while Q = 5 -> lim = 3, no pulse; next up-count gives Q = 0.
- Count canal 0 to 5 and canal 1 to 5 -> todos_fim goes high only after the second channel reaches 5. canal = 2 with P = 2 padded to PW = 1 cannot occur; instead drive P = 3 with canal = 3 -> no change, Q = 0.
- conta and clr in the same cycle with Q = 4 -> Q = 0, no pulse. Assert rst asynchronously between edges mid-count -> all outputs at reset values immediately, lim = 5.
- carrega with limite = 0 -> lim unchanged at 5.
